// File: rtl/cic_pkg.sv
// Shared CIC constants, used by the integrator chain and the comb/decimator so
// that the data widths and stage counts agree across the filter.
package cic_pkg;

  localparam int unsigned CIC_WIDTH  = 18;
  localparam int unsigned CIC_DECIM  = 16;
  localparam int unsigned CIC_STAGES = 3;

  // Width of a counter that runs 0..decim-1.
  function automatic int unsigned cnt_width(input int unsigned decim);
    return (decim < 2) ? 1 : $clog2(decim);
  endfunction

endpackage

// File: rtl/comb_stage.sv
// One CIC comb (differentiator) stage with a differential delay of 1.
// When en is high: y <= x - previous x (mod 2^WIDTH), and x is remembered.
module comb_stage #(
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] delay_q, delay_d;
  logic [WIDTH-1:0] diff_q,  diff_d;

  always_comb begin
    delay_d = delay_q;
    diff_d  = diff_q;
    if (en) begin
      diff_d  = x - delay_q;
      delay_d = x;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      delay_q <= '0;
      diff_q  <= '0;
    end else begin
      delay_q <= delay_d;
      diff_q  <= diff_d;
    end
  end

  assign y = diff_q;

endmodule

// File: rtl/cic_comb_decim.sv
// CIC decimator back end: downsample the last integrator output by DECIM and
// run STAGES pipelined comb stages at the decimated rate.
module cic_comb_decim
  import cic_pkg::*;
#(
  parameter int unsigned WIDTH  = CIC_WIDTH,
  parameter int unsigned DECIM  = CIC_DECIM,
  parameter int unsigned STAGES = CIC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out
);

  localparam int unsigned CNT_W = cnt_width(DECIM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] s0_q, s0_d;
  logic [STAGES:0]  v_q, v_d;
  logic             strobe;

  // chain[0] is the captured sample, chain[k] the output of comb stage k.
  logic [WIDTH-1:0] chain [0:STAGES];

  assign strobe = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = strobe ? '0 : cnt_q + CNT_W'(1);
    s0_d  = strobe ? data_in : s0_q;
    v_d   = {v_q[STAGES-1:0], strobe};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      s0_q  <= '0;
      v_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      s0_q  <= s0_d;
      v_q   <= v_d;
    end
  end

  assign chain[0] = s0_q;

  for (genvar k = 1; k <= STAGES; k++) begin : g_comb
    comb_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (v_q[k-1]),
      .x    (chain[k-1]),
      .y    (chain[k])
    );
  end

  assign data_out  = chain[STAGES];
  assign valid_out = v_q[STAGES];

endmodule

// File: tb/tb_cic_comb_decim.sv
// Directed and model-based checks of cic_comb_decim across several parameter
// sets; each instance is exercised in turn from a single stimulus thread.
module tb_cic_comb_decim;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: DECIM=4, STAGES=1
  logic rst_a = 1'b0; logic [17:0] din_a = '0; logic [17:0] dout_a; logic vout_a;
  // Instance B: DECIM=2, STAGES=3
  logic rst_b = 1'b0; logic [17:0] din_b = '0; logic [17:0] dout_b; logic vout_b;
  // Instance C: DECIM=4, STAGES=3
  logic rst_c = 1'b0; logic [17:0] din_c = '0; logic [17:0] dout_c; logic vout_c;
  // Instance D: defaults (18/16/3)
  logic rst_d = 1'b0; logic [17:0] din_d = '0; logic [17:0] dout_d; logic vout_d;
  // Instance E: DECIM=2, STAGES=1
  logic rst_e = 1'b0; logic [17:0] din_e = '0; logic [17:0] dout_e; logic vout_e;

  cic_comb_decim #(.WIDTH(18), .DECIM(4), .STAGES(1)) u_a (
    .clk(clk), .rst_n(rst_a), .data_in(din_a), .data_out(dout_a), .valid_out(vout_a));
  cic_comb_decim #(.WIDTH(18), .DECIM(2), .STAGES(3)) u_b (
    .clk(clk), .rst_n(rst_b), .data_in(din_b), .data_out(dout_b), .valid_out(vout_b));
  cic_comb_decim #(.WIDTH(18), .DECIM(4), .STAGES(3)) u_c (
    .clk(clk), .rst_n(rst_c), .data_in(din_c), .data_out(dout_c), .valid_out(vout_c));
  cic_comb_decim u_d (
    .clk(clk), .rst_n(rst_d), .data_in(din_d), .data_out(dout_d), .valid_out(vout_d));
  cic_comb_decim #(.WIDTH(18), .DECIM(2), .STAGES(1)) u_e (
    .clk(clk), .rst_n(rst_e), .data_in(din_e), .data_out(dout_e), .valid_out(vout_e));

  typedef struct {
    logic        rst_n;
    logic [17:0] din;
    logic        exp_v;
    logic [17:0] exp_d;
  } vec_t;

  vec_t vecs[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic r, input logic [17:0] d, input logic v,
                              input logic [17:0] e);
    vec_t x;
    x.rst_n = r; x.din = d; x.exp_v = v; x.exp_d = e;
    vecs.push_back(x);
  endfunction

  // Instance A: reset/phase with constant 7, then a ramp of +5 per clock.
  task automatic test_table();
    int ph_d[13] = '{0, 0, 0, 0, 7, 7, 7, 7, 0, 0, 0, 0, 0};
    int rp_d[13] = '{0, 0, 0, 0, 15, 15, 15, 15, 20, 20, 20, 20, 20};
    int vt[13]   = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    add(1'b0, 18'd7, 1'b0, 18'd0);
    add(1'b0, 18'd7, 1'b0, 18'd0);
    for (int t = 0; t < 13; t++) add(1'b1, 18'd7, vt[t][0], 18'(ph_d[t]));
    add(1'b0, 18'd0, 1'b0, 18'd0);
    for (int t = 0; t < 13; t++) add(1'b1, 18'(5 * t), vt[t][0], 18'(rp_d[t]));
    for (int i = 0; i < vecs.size(); i++) begin
      rst_a = vecs[i].rst_n;
      din_a = vecs[i].din;
      cyc();
      chk($sformatf("A.valid[%0d]", i), {31'd0, vout_a}, {31'd0, vecs[i].exp_v});
      chk($sformatf("A.data[%0d]", i), {14'd0, dout_a}, {14'd0, vecs[i].exp_d});
    end
  endtask

  // Instance B: step of 5 through three combs, latency 3 after each capture.
  task automatic test_step();
    logic [17:0] exp_y[5] = '{18'd5, 18'h3FFF6, 18'd5, 18'd0, 18'd0};
    int k = 0;
    rst_b = 1'b0; din_b = 18'd5;
    cyc();
    chk("B.reset_valid", {31'd0, vout_b}, 32'd0);
    rst_b = 1'b1;
    for (int t = 0; t <= 12; t++) begin
      logic ev;
      cyc();
      ev = (t >= 4) && (t % 2 == 0);
      chk($sformatf("B.valid[t%0d]", t), {31'd0, vout_b}, {31'd0, ev});
      if (ev) begin
        chk($sformatf("B.data[%0d]", k), {14'd0, dout_b}, {14'd0, exp_y[k]});
        k++;
      end
    end
  endtask

  // Instance E: integrator wrap 0x3FFF0 -> 0x00010 must difference to 0x20.
  task automatic test_wrap();
    rst_e = 1'b0; din_e = '0;
    cyc();
    rst_e = 1'b1;
    for (int t = 0; t <= 4; t++) begin
      din_e = (t == 1) ? 18'h3FFF0 : (t == 3) ? 18'h00010 : 18'h12345;
      cyc();
      chk($sformatf("E.valid[t%0d]", t), {31'd0, vout_e}, {31'd0, (t == 2 || t == 4)});
      if (t == 2) chk("E.first", {14'd0, dout_e}, 32'h3FFF0);
      if (t == 4) chk("E.wrap", {14'd0, dout_e}, 32'h00020);
    end
  endtask

  // Instance C: reset one edge after a capture kills the in-flight sample.
  task automatic test_mid_reset();
    rst_c = 1'b0; din_c = 18'd9;
    cyc();
    rst_c = 1'b1;
    for (int t = 0; t < 12; t++) cyc();
    rst_c = 1'b0;
    cyc();
    chk("C.rst_valid", {31'd0, vout_c}, 32'd0);
    chk("C.rst_data", {14'd0, dout_c}, 32'd0);
    rst_c = 1'b1;
    for (int t = 0; t <= 8; t++) begin
      cyc();
      chk($sformatf("C.valid[t%0d]", t), {31'd0, vout_c}, {31'd0, (t == 6)});
      if (t == 6) chk("C.fresh_hist", {14'd0, dout_c}, 32'd9);
    end
  endtask

  // Instance D: random input against a direct 3rd-difference model.
  task automatic test_random();
    logic [17:0] h0 = '0, h1 = '0, h2 = '0, h3 = '0;
    logic [17:0] pend[$];
    int due[$];
    int last_v = -1;
    rst_d = 1'b0; din_d = '0;
    cyc();
    chk("D.reset_valid", {31'd0, vout_d}, 32'd0);
    rst_d = 1'b1;
    for (int t = 0; t < 10000; t++) begin
      logic ev;
      din_d = 18'($urandom);
      cyc();
      if (t % 16 == 15) begin
        h3 = h2; h2 = h1; h1 = h0; h0 = din_d;
        pend.push_back(18'(h0 - 3 * h1 + 3 * h2 - h3));
        due.push_back(t + 3);
      end
      ev = (due.size() > 0) && (due[0] == t);
      chk($sformatf("D.valid[t%0d]", t), {31'd0, vout_d}, {31'd0, ev});
      if (ev) begin
        chk($sformatf("D.data[t%0d]", t), {14'd0, dout_d}, {14'd0, pend.pop_front()});
        void'(due.pop_front());
      end
      if (vout_d) begin
        if (last_v >= 0) chk("D.spacing", 32'(t - last_v), 32'd16);
        last_v = t;
      end
    end
  endtask

  initial begin
    cyc();
    test_table();
    test_step();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cic_comb_decim.md
Name: cic_comb_decim

Overview:
Downstream stage of the CIC decimation filter. It takes the full-rate output of the last integrator, downsamples it by DECIM, and runs STAGES pipelined comb (differentiator, differential delay 1) stages at the decimated rate. It produces one filtered sample per DECIM input clocks, qualified by a single-cycle valid strobe, for the output formatter.

Parameters:
WIDTH, 18, data width of the integrator output and of every comb register; all arithmetic is modulo 2^WIDTH.
DECIM, 16, decimation ratio R; legal range >= 2.
STAGES, 3, number of comb stages N; legal range >= 1; must match the integrator count.
CNT_W, $clog2(DECIM), decimation counter width; derived, not overridden.

Ports:
clk  input  1  clock, same domain as the integrators.
rst_n  input  1  synchronous, active-low reset.
data_in  input  WIDTH  unsigned integrator output, new value every clk.
data_out  output  WIDTH  unsigned comb-chain result, registered.
valid_out  output  1  one-cycle strobe; data_out is meaningful while high.

Behaviour:
- Reset: synchronous, active-low, sampled at the clk rising edge; clock is clk.
  - While rst_n=0 at an edge: counter=0, capture reg s0=0, all comb outputs c_k=0, all delay regs d_k=0, valid pipe v[0..STAGES]=0, data_out=0, valid_out=0.
- Decimation counter:
  - Increments every clk; wraps DECIM-1 -> 0.
  - strobe = (counter == DECIM-1).
  - The first strobe is at the DECIM-th edge after rst_n returns high. That edge is cycle index DECIM-1, counting the first edge with rst_n=1 as cycle 0.
- Capture: at an edge with strobe=1, s0 <= data_in and v[0] <= 1. At all other edges v[0] <= 0.
- Comb stage k (1..STAGES), input x = s0 for k=1, otherwise c_{k-1}:
  - At an edge where v[k-1]=1: c_k <= x - d_k (mod 2^WIDTH) and d_k <= x.
  - v[k] <= v[k-1] every edge.
  - c_k and d_k hold when v[k-1]=0.
- Output:
  - data_out = c_STAGES.
  - valid_out = v[STAGES], high exactly 1 cycle.
  - Latency: valid_out rises STAGES cycles after the capture edge.
  - Valid pulses are exactly DECIM cycles apart.
- Arithmetic:
  - Unsigned wrap-around subtraction, no saturation, no width growth.
  - Integrator overflow cancels by design, so a wrapped input must give the correct difference.
- Delay registers start at 0, so the first STAGES outputs after reset are the transient of a zero-history filter. No suppression is applied; downstream discards them.
- Reset mid-operation clears everything, including in-flight valid bits. No valid_out is produced for a sample captured before the reset, and counter phase restarts from 0.
- data_in is not required to be stable between strobes; only the strobe-cycle value is used.

Decomposition:
- Shared package cic_pkg holds:
  - default WIDTH, DECIM and STAGES constants, shared with the integrator chain so the widths agree;
  - a localparam function for CNT_W.
- Sub-module comb_stage (parameter WIDTH; ports clk, rst_n, en, x, y):
  - one delay register and one difference register, updating when en=1.
  - Instantiated STAGES times in a generate loop, with en driven by v[k-1].
- Counter, capture register and valid pipe stay in the top module.

Test Plan:
- Reset/phase (DECIM=4, STAGES=1, data_in=7 constant):
  - data_out=0 and valid_out=0 through reset.
  - First valid_out at cycle 4 after reset release, data_out=7.
  - Subsequent valids every 4 cycles with data_out=0.
- Ramp (DECIM=4, STAGES=1, data_in increments by 5 each clk from 0):
  - Captures are 15, 35, 55, ...
  - Outputs are 15, then 20 on every subsequent valid.
- Step through 3 combs (DECIM=2, STAGES=3, data_in=5 constant):
  - Successive valid outputs are 5, 0x3FFF6, 5, 0, 0.
  - Each valid_out arrives 3 cycles after its capture edge.
- Wrap-around (WIDTH=18, DECIM=2, STAGES=1):
  - Consecutive captured values 0x3FFF0 then 0x00010 -> data_out=0x00020.
- Reset mid-operation (DECIM=4, STAGES=3):
  - Assert rst_n=0 for 1 cycle one edge after a capture.
  - No valid_out for that sample; outputs 0 next cycle.
  - Next capture at cycle 3 after release; delay history restarts from 0.
- Default parameters, random data_in for 10000 cycles:
  - Output matches the reference model (decimate by 16, 3-fold mod-2^18 difference).
  - Pulse spacing is exactly 16 cycles.
